// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the core load/store path, the loader and the data memory.
// The arbiter connects through the slave modport; the environment uses master.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              core_rd;
    logic              core_wr;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic [DATA_W-1:0] core_rdata;
    logic              core_stall;

    logic              ld_req;
    logic              ld_wr;
    logic              ld_last;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_wdata;
    logic              ld_gnt;
    logic [DATA_W-1:0] ld_rdata;
    logic              ld_valid;

    logic              mem_rd;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  core_rd, core_wr, core_addr, core_wdata,
        output core_rdata, core_stall,
        input  ld_req, ld_wr, ld_last, ld_addr, ld_wdata,
        output ld_gnt, ld_rdata, ld_valid,
        output mem_rd, mem_wr, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output core_rd, core_wr, core_addr, core_wdata,
        input  core_rdata, core_stall,
        output ld_req, ld_wr, ld_last, ld_addr, ld_wdata,
        input  ld_gnt, ld_rdata, ld_valid,
        input  mem_rd, mem_wr, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Data memory arbiter: the core owns the port by default; the loader takes it on
// core-idle cycles or after MAX_WAIT denied cycles, for at most MAX_BURST beats.
module dmem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_WAIT  = 4,
    parameter int MAX_BURST = 8
) (
    input logic           clk,
    input logic           rst,
    dmem_arbiter_if.slave bus
);
    localparam int WAIT_W  = (MAX_WAIT  > 1) ? $clog2(MAX_WAIT)  : 1;
    localparam int BEAT_W  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(MAX_BURST - 1);

    typedef enum logic {
        CORE,
        LD
    } state_t;

    state_t            state_q;
    logic [WAIT_W-1:0] wait_q;
    logic [BEAT_W-1:0] beat_q;
    logic [DATA_W-1:0] ld_rdata_q;
    logic              ld_valid_q;

    logic              core_busy;
    logic              ld_eligible;
    logic              ld_read;
    logic              burst_end;

    logic              sel_rd;
    logic              sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [DATA_W-1:0] core_rdata_d;
    logic              stall_d;
    logic              gnt_d;

    assign core_busy   = bus.core_rd | bus.core_wr;
    // A starved loader forces its way in once the wait counter reaches its limit.
    assign ld_eligible = bus.ld_req & (~core_busy | (wait_q == WAIT_LAST));
    assign ld_read     = bus.ld_req & ~bus.ld_wr;
    assign burst_end   = ~bus.ld_req | bus.ld_last | (beat_q == BEAT_LAST);

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= CORE;
            wait_q     <= '0;
            beat_q     <= '0;
            ld_rdata_q <= '0;
            ld_valid_q <= 1'b0;
        end else begin
            case (state_q)
                CORE: begin
                    ld_valid_q <= 1'b0;
                    if (ld_eligible) begin
                        state_q <= LD;
                        wait_q  <= '0;
                        beat_q  <= '0;
                    end else if (bus.ld_req) begin
                        if (wait_q != WAIT_LAST) wait_q <= wait_q + 1'b1;
                    end else begin
                        wait_q <= '0;
                    end
                end
                LD: begin
                    ld_valid_q <= ld_read;
                    if (ld_read) ld_rdata_q <= bus.mem_rdata;
                    // Leaving LD always passes through at least one CORE cycle.
                    if (burst_end) begin
                        state_q <= CORE;
                        beat_q  <= '0;
                    end else begin
                        beat_q <= beat_q + 1'b1;
                    end
                end
                default: state_q <= CORE;
            endcase
        end
    end

    // NOTE: every signal is defaulted before the state override, so no latch is inferred.
    always_comb begin
        sel_rd       = bus.core_rd;
        sel_wr       = bus.core_wr;
        sel_addr     = bus.core_addr;
        sel_wdata    = bus.core_wdata;
        core_rdata_d = bus.mem_rdata;
        stall_d      = 1'b0;
        gnt_d        = 1'b0;
        if (state_q == LD) begin
            sel_rd       = ld_read;
            sel_wr       = bus.ld_req & bus.ld_wr;
            sel_addr     = bus.ld_addr;
            sel_wdata    = bus.ld_wdata;
            core_rdata_d = '0;
            stall_d      = core_busy;
            gnt_d        = bus.ld_req;
        end
    end

    assign bus.mem_rd     = sel_rd;
    // Writes are suppressed for as long as reset is held.
    assign bus.mem_wr     = sel_wr & rst;
    assign bus.mem_addr   = sel_addr;
    assign bus.mem_wdata  = sel_wdata;
    assign bus.core_rdata = core_rdata_d;
    assign bus.core_stall = stall_d;
    assign bus.ld_gnt     = gnt_d;
    assign bus.ld_rdata   = ld_rdata_q;
    assign bus.ld_valid   = ld_valid_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a bus-ownership model with its own memory
// image is compared against every output on each falling edge.
module tb_dmem_arbiter;
    localparam int MAX_WAIT  = 4;
    localparam int MAX_BURST = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    dmem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAX_WAIT), .MAX_BURST(MAX_BURST)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Environment memory: combinational read, write committed on the rising edge.
    logic [31:0] mem [256];
    logic        pend_wr;
    logic [7:0]  pend_idx;
    logic [31:0] pend_data;
    assign bus.mem_rdata = mem[bus.mem_addr[9:2]];

    always @(negedge clk) begin
        pend_wr   = bus.mem_wr;
        pend_idx  = bus.mem_addr[9:2];
        pend_data = bus.mem_wdata;
    end
    always @(posedge clk) if (pend_wr && rst) mem[pend_idx] <= pend_data;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Ownership model: who holds the memory, how long the loader has been refused,
    // how many beats it has taken in the current grant.
    bit          m_loader_owns = 1'b0;
    int          m_denied      = 0;
    int          m_beats       = 0;
    bit          m_valid       = 1'b0;
    logic [31:0] m_rdata       = '0;
    logic [31:0] ref_mem [256];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_loader_owns = 1'b0;
            m_denied      = 0;
            m_beats       = 0;
            m_valid       = 1'b0;
            m_rdata       = '0;
        end else if (!m_loader_owns) begin
            m_valid = 1'b0;
            if (bus.core_wr) ref_mem[bus.core_addr[9:2]] = bus.core_wdata;
            if (bus.ld_req && (!(bus.core_rd || bus.core_wr) || m_denied >= MAX_WAIT - 1)) begin
                m_loader_owns = 1'b1;
                m_denied      = 0;
                m_beats       = 0;
            end else begin
                m_denied = bus.ld_req ? m_denied + 1 : 0;
            end
        end else begin
            m_valid = 1'b0;
            if (!bus.ld_req) begin
                m_loader_owns = 1'b0;
            end else begin
                m_beats++;
                if (bus.ld_wr) begin
                    ref_mem[bus.ld_addr[9:2]] = bus.ld_wdata;
                end else begin
                    m_rdata = ref_mem[bus.ld_addr[9:2]];
                    m_valid = 1'b1;
                end
                if (bus.ld_last || m_beats == MAX_BURST) m_loader_owns = 1'b0;
            end
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        logic        e_rd, e_wr, e_gnt, e_stall;
        logic [31:0] e_addr, e_wdata, e_crd;
        if (m_loader_owns) begin
            e_rd    = bus.ld_req & ~bus.ld_wr;
            e_wr    = bus.ld_req & bus.ld_wr;
            e_addr  = bus.ld_addr;
            e_wdata = bus.ld_wdata;
            e_gnt   = bus.ld_req;
            e_stall = bus.core_rd | bus.core_wr;
            e_crd   = '0;
        end else begin
            e_rd    = bus.core_rd;
            e_wr    = bus.core_wr;
            e_addr  = bus.core_addr;
            e_wdata = bus.core_wdata;
            e_gnt   = 1'b0;
            e_stall = 1'b0;
            e_crd   = ref_mem[bus.core_addr[9:2]];
        end
        e_wr = e_wr & rst;
        check("mem_rd",     32'(bus.mem_rd),     32'(e_rd));
        check("mem_wr",     32'(bus.mem_wr),     32'(e_wr));
        check("mem_addr",   bus.mem_addr,        e_addr);
        check("mem_wdata",  bus.mem_wdata,       e_wdata);
        check("ld_gnt",     32'(bus.ld_gnt),     32'(e_gnt));
        check("core_stall", 32'(bus.core_stall), 32'(e_stall));
        check("core_rdata", bus.core_rdata,      e_crd);
        check("ld_valid",   32'(bus.ld_valid),   32'(m_valid));
        check("ld_rdata",   bus.ld_rdata,        m_rdata);
    end

    logic [31:0] seen [16];
    int          n_seen;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic core_idle();
        bus.core_rd = 1'b0; bus.core_wr = 1'b0; bus.core_addr = '0; bus.core_wdata = '0;
    endtask

    // Loader read burst: holds ld_req, advances the address after each granted beat.
    task automatic run_burst(input logic [31:0] base, input int nbeats, input bit use_last,
                             input int ncycles, output logic [31:0] pat);
        int beat;
        bit granted;
        beat   = 0;
        pat    = '0;
        n_seen = 0;
        bus.ld_req  = 1'b1; bus.ld_wr = 1'b0; bus.ld_addr = base;
        bus.ld_last = use_last && (nbeats == 1);
        for (int c = 0; c < ncycles; c++) begin
            @(negedge clk);
            pat[c]  = bus.ld_gnt;
            granted = bus.ld_gnt;
            if (bus.ld_valid && n_seen < 16) begin
                seen[n_seen] = bus.ld_rdata;
                n_seen++;
            end
            step();
            if (granted && bus.ld_req) begin
                beat++;
                if (beat == nbeats) begin
                    bus.ld_req = 1'b0; bus.ld_last = 1'b0;
                end else begin
                    bus.ld_addr = bus.ld_addr + 32'd4;
                    bus.ld_last = use_last && (beat == nbeats - 1);
                end
            end
        end
    endtask

    initial begin
        logic [31:0] pat;
        logic [31:0] exp_words [10];
        int          n;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = (i < 10) ? 32'hA000_0000 + 32'(i) : 32'h0;
            ref_mem[i] = mem[i];
        end
        core_idle();
        bus.ld_req = 1'b0; bus.ld_wr = 1'b0; bus.ld_last = 1'b0;
        bus.ld_addr = '0; bus.ld_wdata = '0;
        rst = 1'b1;
        #1 rst = 1'b0;

        // Reset held with random inputs; the last cycle forces a core store attempt.
        for (int i = 0; i < 4; i++) begin
            bus.core_rd = 1'($urandom); bus.core_wr = (i == 3) ? 1'b1 : 1'($urandom);
            bus.core_addr = $urandom & 32'h3FC; bus.core_wdata = $urandom;
            bus.ld_req = 1'($urandom); bus.ld_wr = 1'($urandom); bus.ld_last = 1'($urandom);
            bus.ld_addr = $urandom & 32'h3FC; bus.ld_wdata = $urandom;
            @(negedge clk);
            check("rst_core_stall", 32'(bus.core_stall), 32'd0);
            check("rst_ld_gnt",     32'(bus.ld_gnt),     32'd0);
            check("rst_ld_valid",   32'(bus.ld_valid),   32'd0);
            check("rst_mem_wr",     32'(bus.mem_wr),     32'd0);
            step();
        end

        // Release: core store of 0xDEADBEEF to 0x10 goes straight through.
        bus.ld_req = 1'b0; bus.ld_wr = 1'b0; bus.ld_last = 1'b0;
        bus.core_rd = 1'b0; bus.core_wr = 1'b1; bus.core_addr = 32'h10; bus.core_wdata = 32'hDEAD_BEEF;
        rst = 1'b1;
        @(negedge clk);
        check("rel_mem_wr",   32'(bus.mem_wr),     32'd1);
        check("rel_mem_addr", bus.mem_addr,        32'h10);
        check("rel_stall",    32'(bus.core_stall), 32'd0);
        step();
        check("rel_mem_word", mem[4], 32'hDEAD_BEEF);

        // Idle core: single-beat loader write to 0x4, then core reads it back.
        core_idle();
        bus.ld_req = 1'b1; bus.ld_wr = 1'b1; bus.ld_addr = 32'h4;
        bus.ld_wdata = 32'h1234; bus.ld_last = 1'b1;
        @(negedge clk);
        check("idle_gnt_c0", 32'(bus.ld_gnt), 32'd0);
        step();
        @(negedge clk);
        check("idle_gnt_c1", 32'(bus.ld_gnt), 32'd1);
        check("idle_mem_wr", 32'(bus.mem_wr), 32'd1);
        check("idle_addr",   bus.mem_addr,    32'h4);
        step();
        bus.ld_req = 1'b0; bus.ld_wr = 1'b0; bus.ld_last = 1'b0;
        bus.core_rd = 1'b1; bus.core_addr = 32'h4;
        @(negedge clk);
        check("idle_back_gnt", 32'(bus.ld_gnt),  32'd0);
        check("idle_readback", bus.core_rdata,   32'h1234);
        step();

        // Starvation: core reads every cycle; loader forced in after MAX_WAIT cycles.
        bus.core_rd = 1'b1; bus.core_addr = 32'h10;
        bus.ld_req = 1'b1; bus.ld_wr = 1'b0; bus.ld_addr = 32'h10; bus.ld_last = 1'b1;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            if (bus.ld_gnt) break;
            n++;
            step();
        end
        check("starve_gnt_cycle", 32'(n),               32'd4);
        check("starve_stall",     32'(bus.core_stall),  32'd1);
        step();
        bus.ld_req = 1'b0; bus.ld_last = 1'b0;
        @(negedge clk);
        check("starve_reissue_stall", 32'(bus.core_stall), 32'd0);
        check("starve_reissue_data",  bus.core_rdata,      32'hDEAD_BEEF);
        check("starve_ld_valid",      32'(bus.ld_valid),   32'd1);
        check("starve_ld_rdata",      bus.ld_rdata,        32'hDEAD_BEEF);
        step();

        // Burst cap: 10-beat read burst over 0x0..0x24 with an idle core.
        core_idle();
        exp_words[0] = 32'hA000_0000; exp_words[1] = 32'h0000_1234;
        exp_words[2] = 32'hA000_0002; exp_words[3] = 32'hA000_0003;
        exp_words[4] = 32'hDEAD_BEEF; exp_words[5] = 32'hA000_0005;
        exp_words[6] = 32'hA000_0006; exp_words[7] = 32'hA000_0007;
        exp_words[8] = 32'hA000_0008; exp_words[9] = 32'hA000_0009;
        run_burst(32'h0, 10, 1'b1, 14, pat);
        check("cap_gnt_pattern", pat,            32'h0DFE);
        check("cap_valid_count", 32'(n_seen),    32'd10);
        for (int i = 0; i < 10; i++) check($sformatf("cap_data%0d", i), seen[i], exp_words[i]);

        // Early termination after 3 beats, then a fresh burst is capped at 8 again.
        run_burst(32'h40, 3, 1'b0, 6, pat);
        check("early_gnt_pattern", pat,         32'h000E);
        check("early_valid_count", 32'(n_seen), 32'd3);
        run_burst(32'h0, 10, 1'b0, 14, pat);
        check("again_gnt_pattern", pat,         32'h0DFE);

        // Async reset during beat 2 (a write) of a burst.
        bus.ld_req = 1'b1; bus.ld_wr = 1'b0; bus.ld_addr = 32'h8; bus.ld_last = 1'b0;
        @(negedge clk);
        step();
        @(negedge clk);
        check("mid_beat1_gnt", 32'(bus.ld_gnt), 32'd1);
        step();
        bus.ld_wr = 1'b1; bus.ld_addr = 32'h54; bus.ld_wdata = 32'h5555_AAAA;
        @(negedge clk);
        check("mid_beat2_gnt",   32'(bus.ld_gnt),   32'd1);
        check("mid_beat2_valid", 32'(bus.ld_valid), 32'd1);
        check("mid_beat2_rdata", bus.ld_rdata,      32'hA000_0002);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_gnt",    32'(bus.ld_gnt),   32'd0);
        check("mid_rst_valid",  32'(bus.ld_valid), 32'd0);
        check("mid_rst_mem_wr", 32'(bus.mem_wr),   32'd0);
        @(posedge clk);
        step();
        bus.ld_req = 1'b0; bus.ld_wr = 1'b0;
        bus.core_rd = 1'b1; bus.core_addr = 32'h8;
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_gnt",   32'(bus.ld_gnt),     32'd0);
        check("post_rst_stall", 32'(bus.core_stall), 32'd0);
        check("post_rst_rdata", bus.core_rdata,      32'hA000_0002);
        check("post_rst_mem21", mem[21],             32'h0);
        step();
        core_idle();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data memory between two requesters: the processor core's load/store path and a program/data loader (debug/DMA style).
- Core has default priority. The loader wins on core-idle cycles, or when starved for MAX_WAIT cycles; the core is stalled only while the loader actually holds the memory.
- Sits between the core's ALU_out/read_data2/flag signals and the data memory port. Its core_stall output gates the program counter update.

Parameters:
- ADDR_W, 32, address width of both requesters and the memory.
- DATA_W, 32, data width.
- MAX_WAIT, 4, cycles a pending loader request may be denied before forced grant (>=1).
- MAX_BURST, 8, maximum consecutive loader beats per grant (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- core_rd  in  1  core load request, this cycle.
- core_wr  in  1  core store request, this cycle.
- core_addr  in  ADDR_W  core address.
- core_wdata  in  DATA_W  core store data.
- core_rdata  out  DATA_W  core load data.
- core_stall  out  1  core must hold PC/regfile write this cycle.
- ld_req  in  1  loader request; held until granted.
- ld_wr  in  1  loader write (1) / read (0).
- ld_last  in  1  final beat of the loader burst.
- ld_addr  in  ADDR_W  loader address.
- ld_wdata  in  DATA_W  loader write data.
- ld_gnt  out  1  loader beat accepted this cycle.
- ld_rdata  out  DATA_W  registered loader read data.
- ld_valid  out  1  ld_rdata valid, one cycle after a granted read.
- mem_rd  out  1  to data memory read flag.
- mem_wr  out  1  to data memory write flag.
- mem_addr  out  ADDR_W  to data memory address.
- mem_wdata  out  DATA_W  to data memory write data.
- mem_rdata  in  DATA_W  from data memory; combinational read.

Behaviour:
- Reset (rst=0, async): state=CORE, wait_cnt=0, beat_cnt=0, ld_rdata=0, ld_valid=0. All combinational outputs follow state CORE.
- Reset mid-burst aborts the burst. No memory write is issued while rst=0 (mem_wr forced 0).
- State CORE:
  - mem_* driven from core_*; core_rdata=mem_rdata; core_stall=0; ld_gnt=0.
  - Loader is "eligible" when ld_req=1 and either (core_rd|core_wr)=0 or wait_cnt==MAX_WAIT-1.
  - If eligible: next state=LD, wait_cnt<=0, beat_cnt<=0.
  - Else if ld_req=1: wait_cnt<=wait_cnt+1 (saturating at MAX_WAIT-1).
  - Else: wait_cnt<=0.
- State LD:
  - mem_* driven from ld_*, with mem_rd=ld_req&~ld_wr and mem_wr=ld_req&ld_wr.
  - ld_gnt=ld_req; core_stall=core_rd|core_wr; core_rdata=0.
  - On a granted read: ld_rdata<=mem_rdata and ld_valid<=1 at the next edge. Otherwise ld_valid<=0.
  - beat_cnt<=beat_cnt+1 per granted beat.
  - Return to CORE when any of these hold: ld_req=0; ld_last=1 on a granted beat; beat_cnt==MAX_BURST-1 on a granted beat.
  - On a forced return with ld_req still high, stay in CORE at least one cycle before re-entering LD, even if the core is idle.
- Loader handshake:
  - A beat completes on the cycle ld_gnt=1.
  - The loader may change ld_addr/ld_wdata/ld_wr only after a completed beat.
  - ld_req deasserting in LD ends the burst with no beat that cycle.
- Core semantics: a stalled core instruction reissues the same access the next cycle, with identical inputs. The arbiter does not buffer core accesses.
- Widths: all counters use clog2 of their limit; no wrap-around is reachable because of the saturate/exit rules.
- core_rd and core_wr both high is illegal. The arbiter passes both through unchanged (the memory resolves it).
- Latency:
  - Core access: 0 cycles when not stalled.
  - Loader: grant at earliest the cycle after ld_req rises; read data one cycle after grant.
  - Worst-case loader wait: MAX_WAIT cycles. Worst-case core stall: MAX_BURST consecutive cycles.

Test Plan:
- Reset: hold rst=0 with random inputs -> core_stall=0, ld_gnt=0, ld_valid=0, mem_wr=0. Release rst -> core store to addr 0x10 of 0xDEADBEEF is written the same cycle with no stall.
- Idle core: core_rd=core_wr=0, ld_req=1, ld_wr=1, ld_addr=0x4, ld_wdata=0x1234, ld_last=1 -> ld_gnt=1 one cycle later, mem_wr=1 with addr 0x4, then state returns to CORE. A core load of 0x4 then returns 0x1234.
- Starvation: core_rd=1 every cycle, ld_req=1, MAX_WAIT=4 -> ld_gnt rises on the 4th cycle after ld_req. core_stall=1 exactly on that cycle; the core reissue completes the next cycle.
- Burst cap: core idle, MAX_BURST=8, 10-beat read burst on addresses 0x0..0x24 -> 8 consecutive grants, then ld_gnt=0 for one cycle, then 2 grants. Each ld_valid follows its grant by one cycle with matching data.
- Early termination: ld_req drops after beat 3 of a burst -> state returns to CORE the next cycle with beat_cnt reset. A subsequent burst again allows 8 beats.
- Async reset mid-burst: assert rst=0 between clock edges during beat 2 -> ld_gnt and ld_valid drop immediately. Memory is unchanged after beat 1; after release, state is CORE.
